// File: rtl/fixed_point_seq_div.sv
// Sequential sign-magnitude fixed-point divider: restoring division producing one
// quotient bit per clock, with saturation, divide-by-zero flagging and a valid/ready handshake.
module fixed_point_seq_div #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int ITER = N - 1 + Q;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    rem;
    logic [ITER-1:0] work;     // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [N-2:0]    divisor;
    logic            sign;

    logic [N-1:0]    rem_shift;
    logic [N-1:0]    rem_next;
    logic            q_bit;
    logic [ITER-1:0] quot;
    logic [N-2:0]    mag;
    logic            ovf;
    logic            b_zero;
    logic            last_iter;

    assign b_zero    = (b[N-2:0] == '0);
    assign last_iter = (cnt == CW'(ITER - 1));
    assign in_ready  = (state == IDLE);

    // One restoring step on the current partial remainder.
    assign rem_shift = {rem[N-2:0], work[ITER-1]};
    assign q_bit     = (rem_shift >= {1'b0, divisor});
    assign rem_next  = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
    assign quot      = {work[ITER-2:0], q_bit};
    assign ovf       = |quot[ITER-1:N-1];
    assign mag       = ovf ? {(N-1){1'b1}} : quot[N-2:0];

    // NOTE: NBA (<=) for all flop state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = b_zero ? DONE : BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers are ordinary flops, so they take the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            work        <= '0;
            divisor     <= '0;
            sign        <= 1'b0;
            c           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt     <= '0;
                        rem     <= '0;
                        work    <= {a[N-2:0], {Q{1'b0}}};
                        divisor <= b[N-2:0];
                        sign    <= a[N-1] ^ b[N-1];
                        if (b_zero) begin
                            c           <= (a[N-2:0] != '0) ? {a[N-1], {(N-1){1'b1}}} : '0;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt  <= cnt + CW'(1);
                    rem  <= rem_next;
                    work <= quot;
                    if (last_iter) begin
                        // A zero magnitude never carries a negative sign.
                        c           <= {sign & (|mag), mag};
                        div_by_zero <= 1'b0;
                        overflow    <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
